// File: rtl/dmem_responder.sv
// Single-ported word memory behind a valid/ready request channel and a valid/ready
// response channel, with a fixed number of wait states between accept and response.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        busy_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic             accept_d;
  logic             acc_now_d;
  logic             acc_write_d;
  logic [31:0]      acc_addr_d;
  logic [31:0]      acc_wdata_d;
  logic [3:0]       acc_be_d;
  logic             acc_err_d;
  logic [IDX_W-1:0] acc_idx_d;
  logic [31:0]      acc_rdata_d;

  // With zero wait states the access happens on the accept edge itself, so it
  // must use the live request inputs rather than the not-yet-latched copies.
  always_comb begin
    accept_d    = (state_q == IDLE) && req_valid;
    acc_now_d   = (accept_d && (WAIT_CYCLES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1));
    acc_write_d = write_q;
    acc_addr_d  = addr_q;
    acc_wdata_d = wdata_q;
    acc_be_d    = be_q;
    if (accept_d) begin
      acc_write_d = req_write;
      acc_addr_d  = req_addr;
      acc_wdata_d = req_wdata;
      acc_be_d    = req_be;
    end
    acc_err_d   = (acc_addr_d[1:0] != 2'b00) ||
                  ({2'b00, acc_addr_d[31:2]} >= 32'(DEPTH_WORDS));
    acc_idx_d   = acc_addr_d[IDX_W+1:2];
    acc_rdata_d = (acc_err_d || acc_write_d) ? 32'd0 : mem_q[acc_idx_d];
  end

  // Memory is deliberately left out of the reset branch: contents survive reset,
  // and a store still in WAIT when reset hits never reaches the commit below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      if (acc_now_d && acc_write_d && !acc_err_d) begin
        for (int i = 0; i < 4; i++) begin
          if (acc_be_d[i]) mem_q[acc_idx_d][8*i +: 8] <= acc_wdata_d[8*i +: 8];
        end
      end

      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= 4'(WAIT_CYCLES);
            state_q     <= WAIT;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase

      // The access edge always lands in RESP, overriding the per-state choice above.
      if (acc_now_d) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err_d;
        rsp_rdata_q <= acc_rdata_d;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// directed requests feeding a scoreboard that a separate monitor drains.
module tb_dmem_responder;

  localparam int WA = 2;
  localparam int WB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_be;
  logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_be;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .busy(a_busy)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WB)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  bit   seen_a = 1'b0;
  bit   seen_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitors: 'due' is the edge number at which rsp_valid must first be sampled high.
  always @(negedge clk) begin
    if (!reset) seen_a = 1'b0;
    else begin
      if (a_rsp_valid && !seen_a) begin
        seen_a = 1'b1;
        if (qa.size() == 0) check("a_spurious_rsp", 32'd1, 32'd0);
        else check("a_latency", cyc + 1, qa[0].due);
      end
      if (a_rsp_valid && a_rsp_ready && qa.size() > 0) begin
        ea = qa.pop_front();
        check("a_rdata", a_rsp_rdata, ea.rdata);
        check("a_err", {31'd0, a_rsp_err}, {31'd0, ea.err});
        seen_a = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) seen_b = 1'b0;
    else begin
      if (b_rsp_valid && !seen_b) begin
        seen_b = 1'b1;
        if (qb.size() == 0) check("b_spurious_rsp", 32'd1, 32'd0);
        else check("b_latency", cyc + 1, qb[0].due);
      end
      if (b_rsp_valid && b_rsp_ready && qb.size() > 0) begin
        eb = qb.pop_front();
        check("b_rdata", b_rsp_rdata, eb.rdata);
        check("b_err", {31'd0, b_rsp_err}, {31'd0, eb.err});
        seen_b = 1'b0;
      end
    end
  end

  task automatic do_req(input bit sel, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err, input bit keep_valid);
    int n = 0;
    exp_t e;
    if (sel) begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
    end else begin
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
    end
    @(negedge clk);
    while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("req_accept_timeout", 32'(n), 32'd0);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.due   = cyc + 32'(sel ? WB : WA) + 1;
    if (sel) qb.push_back(e);
    else qa.push_back(e);
    if (!keep_valid) begin
      // Scramble the request fields after accept; the response must not notice.
      if (sel) begin
        b_req_valid = 1'b0; b_req_addr = ~addr; b_req_wdata = ~wdata; b_req_be = ~be; b_req_write = ~wr;
      end else begin
        a_req_valid = 1'b0; a_req_addr = ~addr; a_req_wdata = ~wdata; a_req_be = ~be; a_req_write = ~wr;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int unsigned prev;
    reset = 1'b0;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
    check("rst_b_req_ready", {31'd0, b_req_ready}, 32'd1);
    reset = 1'b1;

    do_req(0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h10,  32'h0000AA00, 4'b0010, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'b1111, 32'hDEADAAEF, 1'b0, 0);
    do_req(0, 1'b0, 32'h11,  32'h0,        4'b1111, 32'h0,        1'b1, 0);
    do_req(0, 1'b1, 32'h0,   32'hCAFEF00D, 4'b1111, 32'h0,        1'b0, 0);
    do_req(0, 1'b1, 32'h400, 32'h12345678, 4'b1111, 32'h0,        1'b1, 0);
    do_req(0, 1'b0, 32'h0,   32'h0,        4'b0000, 32'hCAFEF00D, 1'b0, 0);
    do_req(0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'b0000, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADAAEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h3FC, 32'hA5A55A5A, 4'b1111, 32'h0,        1'b0, 0);
    do_req(0, 1'b0, 32'h3FC, 32'h0,        4'b0000, 32'hA5A55A5A, 1'b0, 0);
    drain();

    // Backpressure: response must sit still while rsp_ready is low.
    a_rsp_ready = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0, 0);
    n = 0;
    @(negedge clk);
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("bp_rsp_timeout", 32'(n), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("bp_rsp_rdata", a_rsp_rdata, 32'hDEADAAEF);
      check("bp_rsp_err", {31'd0, a_rsp_err}, 32'd0);
      check("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
      check("bp_busy", {31'd0, a_busy}, 32'd1);
    end
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_busy", {31'd0, a_busy}, 32'd0);
    check("bp_after_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("bp_after_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    drain();

    // Reset in the middle of a store's wait states.
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'h11111111; a_req_be = 4'b1111;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    check("midwait_busy", {31'd0, a_busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, a_req_ready}, 32'd1);
    check("midrst_busy", {31'd0, a_busy}, 32'd0);
    check("midrst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("midrst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
    check("midrst_rsp_rdata", a_rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0, 0);
    drain();

    // Zero wait states, request held valid back to back.
    do_req(1, 1'b1, 32'h20, 32'h13572468, 4'b1111, 32'h0, 1'b0, 1);
    prev = acc_cyc;
    do_req(1, 1'b0, 32'h20, 32'h0, 4'b0000, 32'h13572468, 1'b0, 1);
    check("b_accept_spacing", acc_cyc - prev, 32'd2);
    prev = acc_cyc;
    do_req(1, 1'b0, 32'h22, 32'h0, 4'b0000, 32'h0, 1'b1, 1);
    check("b_accept_spacing", acc_cyc - prev, 32'd2);
    prev = acc_cyc;
    do_req(1, 1'b1, 32'h24, 32'h00C30000, 4'b0100, 32'h0, 1'b0, 0);
    check("b_accept_spacing", acc_cyc - prev, 32'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit memory words.
REQ-003 Parameter WAIT_CYCLES, default 2, SHALL set the wait states between request accept and response; the legal range is 0..15.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  the core presents a request.
REQ-007 req_ready  output  1  the responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_be  input  4  byte enables for a store; bit i selects byte i.
REQ-012 rsp_valid  output  1  a response is presented.
REQ-013 rsp_ready  input  1  the core accepts the response.
REQ-014 rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  the access was misaligned or out of range.
REQ-016 busy  output  1  the FSM is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1. On accept, the block SHALL latch addr, write, wdata and be, and load the wait counter with WAIT_CYCLES.
REQ-020 IDLE to WAIT on accept when WAIT_CYCLES>0; IDLE to RESP on accept when WAIT_CYCLES=0.
REQ-021 In WAIT the counter SHALL decrement each cycle. When the counter is 1, the next edge SHALL perform the access and move to RESP.
REQ-022 Latency: rsp_valid SHALL first be high exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-023 The access SHALL be performed on the edge that enters RESP: the memory write commit, plus capture of rsp_rdata and rsp_err.
REQ-024 Error case: req_addr[1:0]!=0, or req_addr[31:2]>=DEPTH_WORDS, SHALL set rsp_err=1 and rsp_rdata=0. No memory write SHALL occur.
REQ-025 Load, no error: rsp_rdata SHALL be the full word at req_addr[31:2]; req_be is ignored.
REQ-026 Store, no error: only bytes with req_be[i]=1 SHALL be updated, and rsp_rdata=0. A store with be=4'b0000 SHALL change nothing and SHALL NOT set rsp_err.
REQ-027 RESP SHALL hold rsp_valid=1 with rsp_rdata and rsp_err stable until rsp_ready=1.
REQ-028 On an edge with rsp_valid=1 and rsp_ready=1, RESP SHALL go to IDLE; req_ready SHALL rise the cycle after the handshake. No same-cycle accept is allowed.
REQ-029 rsp_ready while not in RESP SHALL be ignored. req_valid while not in IDLE SHALL be ignored and SHALL NOT be queued.
REQ-030 Request inputs SHALL NOT be sampled after the accept edge; changing them during WAIT or RESP SHALL have no effect.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 While reset=0, state SHALL be IDLE, the counter 0, req_ready=1 and busy=0; rsp_valid, rsp_err and rsp_rdata SHALL be 0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset during WAIT SHALL abort a pending store with no memory change. A store already committed on entry to RESP SHALL persist through reset.
REQ-035 Reset release SHALL be usable on any edge; the first accept is possible on the first edge with reset=1.

Verification
REQ-036 WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, be=1111, then load 0x10. rsp_valid SHALL rise 3 cycles after each accept; the load SHALL return rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Partial store: be=0010, wdata=0x0000AA00 to 0x10. A subsequent load SHALL return 0xDEADAAEF.
REQ-038 Errors: a load of 0x11 SHALL return rsp_err=1, rsp_rdata=0. A store of 0x12345678 to 0x400 (DEPTH 256) SHALL return rsp_err=1, and a reload of word 0 SHALL be unchanged.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles in RESP. rsp_valid, rsp_rdata and rsp_err SHALL be stable, req_ready=0 and busy=1; IDLE SHALL follow the handshake edge.
REQ-040 Reset mid-WAIT: assert reset during WAIT of a store of 0x11111111 to 0x10. All outputs SHALL take their reset values immediately, and a subsequent load SHALL return 0xDEADAAEF.
REQ-041 WAIT_CYCLES=0: back-to-back requests with rsp_ready=1. rsp_valid SHALL rise 1 cycle after each accept, with accepts spaced exactly 2 cycles apart.
